// File: rtl/i2c_target_regs_pkg.sv
// Shared definitions for the I2C target register block: FSM states,
// ACK/NACK levels and pointer arithmetic.
package i2c_target_regs_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK
  } state_t;

  localparam logic       I2C_ACK  = 1'b0;
  localparam logic       I2C_NACK = 1'b1;
  localparam logic [2:0] BIT_MSB  = 3'd7;

  // Register pointer advance with wrap from the last register back to 0.
  function automatic logic [7:0] ptr_inc(input logic [7:0] ptr, input logic [7:0] last);
    return (ptr == last) ? 8'd0 : ptr + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_target_regs_if.sv
// I2C pin bundle. SDA is open drain: the target only ever pulls low via OE_sda.
interface i2c_target_regs_if;
  logic I_scl;
  logic I_sda;
  logic O_sda;
  logic OE_sda;

  modport slave  (input I_scl, input I_sda, output O_sda, output OE_sda);
  modport master (output I_scl, output I_sda, input O_sda, input OE_sda);
endinterface

// File: rtl/i2c_target_regs_bus_sync.sv
// SCL/SDA synchroniser with SCL edge and START/STOP condition pulses,
// all derived from the synchronised copies only.
module i2c_target_regs_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_scl,
  input  logic I_sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sh, sda_sh;
  logic scl_s, scl_d, sda_d;

  // Reset to the idle-bus level so no spurious edge appears after reset.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      scl_sh <= '1;
      sda_sh <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_sh <= {scl_sh[SYNC_STAGES-2:0], I_scl};
      sda_sh <= {sda_sh[SYNC_STAGES-2:0], I_sda};
      scl_d  <= scl_s;
      sda_d  <= sda_s;
    end
  end

  assign scl_s    = scl_sh[SYNC_STAGES-1];
  assign sda_s    = sda_sh[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an N-byte register file: pointer write, burst write with
// auto-increment, and multi-byte reads terminated by master NACK.
module i2c_target_regs
  import i2c_target_regs_pkg::*;
#(
  parameter int         NUM_REGS    = 4,
  parameter logic [2:0] ADDR_LO     = 3'b100,
  parameter logic [7:0] REG_RST     = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  i2c_target_regs_if.slave      bus,
  input  logic [3:0]            I_myaddr,
  output logic [8*NUM_REGS-1:0] O_regs,
  output logic                  O_wr_stb,
  output logic [7:0]            O_wr_idx,
  output logic                  O_busy,
  output state_t                O_state
);

  localparam logic [7:0] LAST_IDX   = 8'(NUM_REGS - 1);
  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_target_regs_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .I_clk    (I_clk),
    .I_rst_n  (I_rst_n),
    .I_scl    (bus.I_scl),
    .I_sda    (bus.I_sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t               state_q, state_n;
  logic [2:0]           bit_cnt_q, bit_cnt_n;
  logic [7:0]           shift_q, shift_n;
  logic [7:0]           ptr_q, ptr_n;
  logic                 oe_q, oe_n;
  logic                 busy_q, busy_n;
  logic                 wr_en, wr_stb_q, drive_low;
  logic [7:0]           wr_idx_q, byte_in, rd_byte;
  logic [8*NUM_REGS-1:0] regs_q;

  assign byte_in = {shift_q[6:0], sda_s};

  always_comb begin
    rd_byte = 8'h00;
    for (int k = 0; k < NUM_REGS; k++)
      if (ptr_q == 8'(k)) rd_byte = regs_q[8*k +: 8];
  end

  // Level to present on SDA for the bit that starts at this SCL fall.
  always_comb begin
    drive_low = 1'b0;
    case (state_q)
      ST_ADDR_ACK, ST_REG_ACK, ST_WR_ACK: drive_low = 1'b1;
      ST_RD:                              drive_low = ~rd_byte[bit_cnt_q];
      default:                            drive_low = 1'b0;
    endcase
  end

  always_comb begin
    state_n   = state_q;
    bit_cnt_n = bit_cnt_q;
    shift_n   = shift_q;
    ptr_n     = ptr_q;
    oe_n      = oe_q;
    busy_n    = busy_q;
    wr_en     = 1'b0;
    if (start) begin
      state_n   = ST_ADDR;
      bit_cnt_n = BIT_MSB;
      oe_n      = 1'b0;
    end else if (stop) begin
      state_n = ST_IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      if (scl_fall) oe_n = drive_low;
      if (scl_rise) begin
        bit_cnt_n = bit_cnt_q - 3'd1;
        case (state_q)
          ST_ADDR: begin
            shift_n = byte_in;
            if (bit_cnt_q == 3'd0) begin
              if (byte_in[7:1] == {I_myaddr, ADDR_LO}) begin
                state_n = ST_ADDR_ACK;
                busy_n  = 1'b1;
              end else begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
              end
            end
          end
          ST_ADDR_ACK: begin
            // shift_q still holds the address byte; bit 0 is R/W.
            state_n   = shift_q[0] ? ST_RD : ST_REG;
            bit_cnt_n = BIT_MSB;
          end
          ST_REG: begin
            shift_n = byte_in;
            if (bit_cnt_q == 3'd0) begin
              if ({1'b0, byte_in} < NUM_REGS_W) begin
                state_n = ST_REG_ACK;
                ptr_n   = byte_in;
              end else begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
              end
            end
          end
          ST_WR: begin
            shift_n = byte_in;
            if (bit_cnt_q == 3'd0) begin
              wr_en   = 1'b1;
              ptr_n   = ptr_inc(ptr_q, LAST_IDX);
              state_n = ST_WR_ACK;
            end
          end
          ST_REG_ACK, ST_WR_ACK: begin
            state_n   = ST_WR;
            bit_cnt_n = BIT_MSB;
          end
          ST_RD: begin
            if (bit_cnt_q == 3'd0) state_n = ST_RD_ACK;
          end
          ST_RD_ACK: begin
            ptr_n     = ptr_inc(ptr_q, LAST_IDX);
            bit_cnt_n = BIT_MSB;
            if (sda_s == I2C_ACK) begin
              state_n = ST_RD;
            end else begin
              state_n = ST_IDLE;
              busy_n  = 1'b0;
            end
          end
          default: bit_cnt_n = bit_cnt_q;
        endcase
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= BIT_MSB;
      shift_q   <= 8'h00;
      ptr_q     <= 8'h00;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= 8'h00;
      regs_q    <= {NUM_REGS{REG_RST}};
    end else begin
      state_q   <= state_n;
      bit_cnt_q <= bit_cnt_n;
      shift_q   <= shift_n;
      ptr_q     <= ptr_n;
      oe_q      <= oe_n;
      busy_q    <= busy_n;
      wr_stb_q  <= wr_en;
      if (wr_en) begin
        wr_idx_q <= ptr_q;
        for (int k = 0; k < NUM_REGS; k++)
          if (ptr_q == 8'(k)) regs_q[8*k +: 8] <= byte_in;
      end
    end
  end

  assign bus.O_sda  = 1'b0;
  assign bus.OE_sda = oe_q;
  assign O_regs     = regs_q;
  assign O_wr_stb   = wr_stb_q;
  assign O_wr_idx   = wr_idx_q;
  assign O_busy     = busy_q;
  assign O_state    = state_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, write/read scoreboards,
// table of single-register write transactions plus hand-written sequences.
module tb_i2c_target_regs;
  import i2c_target_regs_pkg::*;

  localparam int NUM_REGS = 4;
  localparam int Q        = 8;   // clocks per quarter SCL period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  m_scl = 1'b1;
  logic                  m_sda = 1'b1;
  logic [3:0]            myaddr = 4'h5;
  logic [8*NUM_REGS-1:0] regs;
  logic                  wr_stb;
  logic [7:0]            wr_idx;
  logic                  busy;
  state_t                dbg_state;

  i2c_target_regs_if bus ();
  assign bus.I_scl = m_scl;
  assign bus.I_sda = m_sda & ~bus.OE_sda;

  i2c_target_regs #(
    .NUM_REGS(NUM_REGS), .ADDR_LO(3'b100), .REG_RST(8'h00), .SYNC_STAGES(2)
  ) dut (
    .I_clk    (clk),
    .I_rst_n  (rst_n),
    .bus      (bus),
    .I_myaddr (myaddr),
    .O_regs   (regs),
    .O_wr_stb (wr_stb),
    .O_wr_idx (wr_idx),
    .O_busy   (busy),
    .O_state  (dbg_state)
  );

  typedef struct {
    logic [6:0] addr;
    logic [7:0] ptr;
    logic [7:0] data;
    logic       exp_addr_ack;
    logic       exp_ptr_ack;
  } txn_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  rd_exp_q[$];
  logic [7:0]  model_regs [NUM_REGS];
  logic [7:0]  model_ptr;
  logic [15:0] wr_e;
  txn_t        vec [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    tick(Q);
    m_scl = 1'b1; tick(2*Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    b = bus.I_sda; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    acked = (b == I2C_ACK);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(master_ack);
  endtask

  task automatic check_regs(input string name);
    for (int k = 0; k < NUM_REGS; k++) check(name, regs[8*k +: 8], model_regs[k]);
  endtask

  task automatic compare_read(input logic [7:0] got);
    if (rd_exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL rd_unexpected: got 0x%0h expected no read", got);
    end else begin
      check("rd_data", got, rd_exp_q.pop_front());
    end
  endtask

  task automatic write_txn(input txn_t t);
    logic a, p, d;
    i2c_start();
    write_byte({t.addr, 1'b0}, a);
    check("addr_ack", a, t.exp_addr_ack);
    if (a) begin
      check("busy_after_addr", busy, 1);
      write_byte(t.ptr, p);
      check("ptr_ack", p, t.exp_ptr_ack);
      if (p) begin
        model_ptr = t.ptr;
        exp_q.push_back({model_ptr, t.data});
        model_regs[model_ptr] = t.data;
        model_ptr = (model_ptr == 8'(NUM_REGS - 1)) ? 8'd0 : model_ptr + 8'd1;
      end else begin
        check("state_after_ptr_nack", dbg_state, ST_IDLE);
        check("busy_after_ptr_nack", busy, 0);
      end
      write_byte(t.data, d);
      check("data_ack", d, p);
    end else begin
      check("busy_no_match", busy, 0);
    end
    i2c_stop();
    check("busy_after_stop", busy, 0);
    check("state_after_stop", dbg_state, ST_IDLE);
    check_regs("regs_after_txn");
  endtask

  // Write scoreboard: every strobe must match the next expected {idx,data}.
  always @(negedge clk) begin
    if (rst_n && wr_stb) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr_unexpected: got idx 0x%0h expected no write", wr_idx);
      end else begin
        wr_e = exp_q.pop_front();
        check("wr_idx_data", {wr_idx, regs[8*wr_idx +: 8]}, wr_e);
      end
    end
  end

  initial begin
    logic       a, p, d;
    logic [7:0] rd;

    vec[0] = '{7'h2C, 8'd2, 8'h4A, 1'b1, 1'b1};
    vec[1] = '{7'h2C, 8'd0, 8'hA5, 1'b1, 1'b1};
    vec[2] = '{7'h2C, 8'd1, 8'h3C, 1'b1, 1'b1};
    vec[3] = '{7'h2D, 8'd1, 8'hFF, 1'b0, 1'b0};
    vec[4] = '{7'h2C, 8'h07, 8'h55, 1'b1, 1'b0};
    vec[5] = '{7'h4C, 8'd3, 8'h99, 1'b0, 1'b0};
    for (int i = 6; i < 8; i++)
      vec[i] = '{7'h2C, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b1, 1'b1};
    for (int k = 0; k < NUM_REGS; k++) model_regs[k] = 8'h00;
    model_ptr = 8'd0;

    // Reset state
    tick(4);
    check("rst_oe", bus.OE_sda, 0);
    check("rst_o_sda", bus.O_sda, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_wr_idx", wr_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    check_regs("rst_regs");
    rst_n = 1'b1;
    tick(4);

    for (int i = 0; i < 8; i++) write_txn(vec[i]);

    // Burst write wrapping from the last register to register 0
    i2c_start();
    write_byte(8'h58, a); check("burst_addr_ack", a, 1);
    write_byte(8'd3, p);  check("burst_ptr_ack", p, 1);
    exp_q.push_back({8'd3, 8'h11}); model_regs[3] = 8'h11;
    write_byte(8'h11, d); check("burst_d0_ack", d, 1);
    exp_q.push_back({8'd0, 8'h22}); model_regs[0] = 8'h22;
    write_byte(8'h22, d); check("burst_d1_ack", d, 1);
    i2c_stop();
    check_regs("burst_regs");

    // Pointer set, repeated START, two-byte read ACK then NACK
    i2c_start();
    write_byte(8'h58, a); check("rs_addr_ack", a, 1);
    write_byte(8'd1, p);  check("rs_ptr_ack", p, 1);
    i2c_start();
    write_byte(8'h59, a); check("rs_rd_addr_ack", a, 1);
    rd_exp_q.push_back(model_regs[1]);
    rd_exp_q.push_back(model_regs[2]);
    read_byte(I2C_ACK, rd);  compare_read(rd);
    read_byte(I2C_NACK, rd); compare_read(rd);
    check("rd_oe_after_nack", bus.OE_sda, 0);
    check("rd_state_after_nack", dbg_state, ST_IDLE);
    check("rd_busy_after_nack", busy, 0);
    i2c_stop();

    // Read without a pointer write continues from the incremented pointer (3)
    i2c_start();
    write_byte(8'h59, a); check("cont_addr_ack", a, 1);
    rd_exp_q.push_back(model_regs[3]);
    read_byte(I2C_NACK, rd); compare_read(rd);
    i2c_stop();

    // Reset while driving a read-data 0 bit (pointer wrapped to 0, regs[0]=0x22)
    i2c_start();
    write_byte(8'h59, a); check("rr_addr_ack", a, 1);
    m_scl = 1'b1; tick(4);
    check("rr_oe_driving", bus.OE_sda, 1);
    rst_n = 1'b0; tick(1);
    check("rr_oe_released", bus.OE_sda, 0);
    check("rr_state", dbg_state, ST_IDLE);
    check("rr_busy", busy, 0);
    for (int k = 0; k < NUM_REGS; k++) model_regs[k] = 8'h00;
    model_ptr = 8'd0;
    check_regs("rr_regs");
    m_sda = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(4);

    write_txn('{7'h2C, 8'd1, 8'h77, 1'b1, 1'b1});

    tick(10);
    check("wr_queue_empty", exp_q.size(), 0);
    check("rd_queue_empty", rd_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
